// File: rtl/sm_dmem_io.sv
// Data-memory responder: aliased word RAM plus an I/O page with GPIO and a compare timer.
// Define SM_DMEM_IO_PRESCALER_EN to add a 16-bit timer prescaler at I/O offset 6.
module sm_dmem_io #(
    parameter int unsigned RAM_AW = 6,
    parameter int unsigned GPIO_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       dmAddr,
    input  logic              dmWe,
    input  logic [31:0]       dmWData,
    output logic [31:0]       dmRData,
    input  logic [GPIO_W-1:0] gpioIn,
    output logic [GPIO_W-1:0] gpioOut,
    output logic              timerIrq
);
    localparam int unsigned RAM_DEPTH = 1 << RAM_AW;

    logic [31:0]       ram [RAM_DEPTH];
    logic [GPIO_W-1:0] gpio_out;
    logic [GPIO_W-1:0] sync1;
    logic [GPIO_W-1:0] sync2;
    logic [31:0]       cnt;
    logic [31:0]       cmp;
    logic [2:0]        ctrl;
    logic              match;

    logic              io_sel;
    logic [3:0]        off;
    logic              io_we;
    logic              ram_we;
    logic              tick;
    logic              step;
    logic              hit;
    logic [31:0]       cnt_step;
    logic [31:0]       io_rdata;
    logic              unused_addr;

    assign io_sel      = dmAddr[31];
    assign off         = dmAddr[3:0];
    assign io_we       = dmWe & io_sel;
    assign ram_we      = dmWe & ~io_sel & ~rst;
    // Only bit 31, the RAM index and the I/O offset are decoded.
    assign unused_addr = ^dmAddr;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[dmAddr[RAM_AW-1:0]] <= dmWData;
        end
    end

`ifdef SM_DMEM_IO_PRESCALER_EN
    logic [15:0] presc;
    logic [15:0] pcnt;

    assign tick = (pcnt == presc);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            pcnt  <= '0;
        end else if (io_we && off == 4'd6) begin
            presc <= dmWData[15:0];
            pcnt  <= '0;
        end else if (ctrl[0]) begin
            pcnt <= tick ? '0 : pcnt + 16'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    assign step     = ctrl[0] & tick;
    // Match uses the pre-write count, so a CNT write in the same cycle cannot mask it.
    assign hit      = step & (cnt == cmp);
    assign cnt_step = (hit && ctrl[1]) ? 32'd0 : cnt + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_out <= '0;
            sync1    <= '0;
            sync2    <= '0;
            cnt      <= '0;
            cmp      <= '0;
            ctrl     <= '0;
            match    <= 1'b0;
        end else begin
            sync1 <= gpioIn;
            sync2 <= sync1;
            if (io_we && off == 4'd0) begin
                gpio_out <= dmWData[GPIO_W-1:0];
            end
            if (io_we && off == 4'd2) begin
                cnt <= dmWData;
            end else if (step) begin
                cnt <= cnt_step;
            end
            if (io_we && off == 4'd3) begin
                cmp <= dmWData;
            end
            if (io_we && off == 4'd4) begin
                ctrl <= dmWData[2:0];
            end
            if (hit) begin
                match <= 1'b1;
            end else if (io_we && off == 4'd5 && dmWData[0]) begin
                match <= 1'b0;
            end
        end
    end

    always_comb begin
        io_rdata = '0;
        case (off)
            4'd0: io_rdata = 32'(gpio_out);
            4'd1: io_rdata = 32'(sync2);
            4'd2: io_rdata = cnt;
            4'd3: io_rdata = cmp;
            4'd4: io_rdata = {29'd0, ctrl};
            4'd5: io_rdata = {31'd0, match};
`ifdef SM_DMEM_IO_PRESCALER_EN
            4'd6: io_rdata = {16'd0, presc};
`endif
            default: io_rdata = '0;
        endcase
    end

    assign dmRData  = io_sel ? io_rdata : ram[dmAddr[RAM_AW-1:0]];
    assign gpioOut  = gpio_out;
    assign timerIrq = match & ctrl[2];

endmodule

// File: tb/tb_sm_dmem_io.sv
// Bench for sm_dmem_io: directed vector table, prescaler sequence and a randomized
// run against a behavioural model of the memory map and timer rules.
module tb_sm_dmem_io;
    localparam logic [31:0] IO = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] dmAddr;
    logic        dmWe;
    logic [31:0] dmWData;
    logic [31:0] dmRData;
    logic [15:0] gpioIn;
    logic [15:0] gpioOut;
    logic        timerIrq;

    int n_cmp = 0;
    int n_bad = 0;

    sm_dmem_io #(
        .RAM_AW (6),
        .GPIO_W (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .dmAddr   (dmAddr),
        .dmWe     (dmWe),
        .dmWData  (dmWData),
        .dmRData  (dmRData),
        .gpioIn   (gpioIn),
        .gpioOut  (gpioOut),
        .timerIrq (timerIrq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [15:0] gin;
        logic        chk;
        logic [31:0] rd;
        logic [15:0] gout;
        logic        irq;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] t_gin;
    logic [15:0] t_gout;
    logic        t_irq;

    task automatic add(input logic r, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic chk, input logic [31:0] exp_rd);
        vec_t v;
        v.rst  = r;
        v.we   = we;
        v.addr = a;
        v.wd   = wd;
        v.gin  = t_gin;
        v.chk  = chk;
        v.rd   = exp_rd;
        v.gout = t_gout;
        v.irq  = t_irq;
        vecs.push_back(v);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp_rd);
        add(1'b0, 1'b0, a, 32'd0, 1'b1, exp_rd);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd);
        add(1'b0, 1'b1, a, wd, 1'b1, exp_rd);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_ram [64];
    bit          m_valid [64];
    logic [15:0] m_gout;
    logic [15:0] gq[$];
    logic [31:0] m_cnt;
    logic [31:0] m_cmp;
    logic [2:0]  m_ctrl;
    logic        m_match;
    logic [15:0] m_presc;
    logic [15:0] m_pcnt;

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (!a[31]) return m_ram[a[5:0]];
        case (int'(a[3:0]))
            0: return {16'd0, m_gout};
            1: return {16'd0, gq[0]};
            2: return m_cnt;
            3: return m_cmp;
            4: return {29'd0, m_ctrl};
            5: return {31'd0, m_match};
`ifdef SM_DMEM_IO_PRESCALER_EN
            6: return {16'd0, m_presc};
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge(input logic r, input logic we, input logic [31:0] a,
                              input logic [31:0] wd, input logic [15:0] gi);
        logic tk;
        logic fired;
        if (r) begin
            m_gout = 0; m_cnt = 0; m_cmp = 0; m_ctrl = 0; m_match = 0;
            m_presc = 0; m_pcnt = 0;
            gq = '{16'h0, 16'h0};
        end else begin
            gq.push_back(gi);
            void'(gq.pop_front());
`ifdef SM_DMEM_IO_PRESCALER_EN
            tk = (m_pcnt == m_presc);
            if (m_ctrl[0]) m_pcnt = tk ? 16'd0 : m_pcnt + 16'd1;
`else
            tk = 1'b1;
`endif
            fired = m_ctrl[0] && tk && (m_cnt == m_cmp);
            if (m_ctrl[0] && tk) m_cnt = (fired && m_ctrl[1]) ? 32'd0 : m_cnt + 32'd1;
            if (fired) m_match = 1'b1;
            if (we) begin
                if (!a[31]) begin
                    m_ram[a[5:0]]   = wd;
                    m_valid[a[5:0]] = 1'b1;
                end else begin
                    case (int'(a[3:0]))
                        0: m_gout = wd[15:0];
                        2: m_cnt = wd;
                        3: m_cmp = wd;
                        4: m_ctrl = wd[2:0];
                        5: if (wd[0] && !fired) m_match = 1'b0;
`ifdef SM_DMEM_IO_PRESCALER_EN
                        6: begin m_presc = wd[15:0]; m_pcnt = 16'd0; end
`endif
                        default: ;
                    endcase
                end
            end
        end
    endtask

    task automatic cycle(input logic chk, input logic r, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [15:0] gi, output logic [31:0] seen);
        rst = r; dmWe = we; dmAddr = a; dmWData = wd; gpioIn = gi;
        @(negedge clk);
        seen = dmRData;
        if (chk) begin
            if (a[31] || m_valid[a[5:0]]) check("model_rd", dmRData, model_rd(a));
            check("model_gout", {16'd0, gpioOut}, {16'd0, m_gout});
            check("model_irq", {31'd0, timerIrq}, {31'd0, m_match & m_ctrl[2]});
        end
        @(posedge clk);
        model_edge(r, we, a, wd, gi);
        #1;
    endtask

    initial begin
        logic [31:0] seen;
        logic [31:0] a;
        logic [31:0] wd;
        logic        we;
        logic        r;

        rst = 1'b1; dmWe = 1'b0; dmAddr = '0; dmWData = '0; gpioIn = '0;
        t_gin = 16'h0; t_gout = 16'h0; t_irq = 1'b0;

        add(1'b1, 1'b1, IO, 32'hFFFF, 1'b0, 32'd0);
        rd(IO, 0); rd(IO + 2, 0); rd(IO + 3, 0); rd(IO + 4, 0); rd(IO + 5, 0);
        add(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0, 32'd0);
        rd(32'd5, 32'hDEAD_BEEF); rd(32'd69, 32'hDEAD_BEEF); rd(32'h7FFF_FFC5, 32'hDEAD_BEEF);
        wr(32'd5, 32'h1, 32'hDEAD_BEEF);
        rd(32'd5, 32'h1);
        wr(IO, 32'h12345, 0);
        t_gout = 16'h2345;
        rd(IO, 32'h2345);
        t_gin = 16'hA5A5;
        rd(IO + 1, 0); rd(IO + 1, 0); rd(IO + 1, 32'hA5A5);
        wr(IO + 9, 32'h5555, 0); rd(IO + 9, 0);
        wr(IO + 32'h10, 32'hABCD, 32'h2345);
        t_gout = 16'hABCD;
        rd(32'h8FF0_0000, 32'hABCD);
        // one-shot: CMP=3, EN|IRQEN
        wr(IO + 3, 3, 0); wr(IO + 4, 5, 0);
        rd(IO + 2, 0); rd(IO + 2, 1); rd(IO + 2, 2); rd(IO + 2, 3);
        t_irq = 1'b1;
        rd(IO + 5, 1); rd(IO + 2, 5); wr(IO + 5, 1, 1);
        t_irq = 1'b0;
        rd(IO + 5, 0);
        wr(IO + 2, 100, 8); rd(IO + 2, 100); rd(IO + 2, 101);
        // auto-reload: CMP=2, EN|AUTORELOAD
        wr(IO + 4, 0, 5); wr(IO + 2, 0, 103); wr(IO + 3, 2, 3); wr(IO + 4, 32'hFFFF_FFF3, 0);
        rd(IO + 2, 0); rd(IO + 2, 1); rd(IO + 2, 2); rd(IO + 2, 0); rd(IO + 2, 1);
        wr(IO + 5, 1, 1); rd(IO + 5, 1); rd(IO + 4, 3);
        wr(IO + 4, 7, 3);
        t_irq = 1'b1;
        rd(IO + 5, 1); wr(IO + 5, 0, 1); rd(IO + 5, 1);
        add(1'b1, 1'b1, IO, 32'hFFFF, 1'b0, 32'd0);
        t_gout = 16'h0; t_irq = 1'b0;
        rd(IO + 1, 0); rd(IO, 0); rd(IO + 2, 0); rd(IO + 3, 0); rd(IO + 4, 0); rd(IO + 5, 0);
        rd(32'd5, 32'h1);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; dmWe = vecs[i].we; dmAddr = vecs[i].addr;
            dmWData = vecs[i].wd; gpioIn = vecs[i].gin;
            @(negedge clk);
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_rd", i), dmRData, vecs[i].rd);
                check($sformatf("vec%0d_gout", i), {16'd0, gpioOut}, {16'd0, vecs[i].gout});
                check($sformatf("vec%0d_irq", i), {31'd0, timerIrq}, {31'd0, vecs[i].irq});
            end
            @(posedge clk);
            #1;
        end

        // resynchronise model and DUT, then make every RAM word known
        cycle(1'b0, 1'b1, 1'b0, IO, 32'd0, 16'h0, seen);
        for (int i = 0; i < 64; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 32'(i), $urandom, 16'($urandom), seen);
        end

`ifdef SM_DMEM_IO_PRESCALER_EN
        begin
            logic [31:0] exp_cnt [6];
            exp_cnt = '{0, 0, 0, 1, 1, 1};
            cycle(1'b1, 1'b0, 1'b1, IO + 4, 0, 16'h0, seen);
            cycle(1'b1, 1'b0, 1'b1, IO + 6, 2, 16'h0, seen);
            cycle(1'b1, 1'b0, 1'b1, IO + 2, 0, 16'h0, seen);
            cycle(1'b1, 1'b0, 1'b1, IO + 3, 1, 16'h0, seen);
            cycle(1'b1, 1'b0, 1'b1, IO + 5, 1, 16'h0, seen);
            cycle(1'b1, 1'b0, 1'b1, IO + 4, 1, 16'h0, seen);
            for (int i = 0; i < 6; i++) begin
                cycle(1'b1, 1'b0, 1'b0, IO + 2, 0, 16'h0, seen);
                check($sformatf("presc_cnt%0d", i), seen, exp_cnt[i]);
            end
            cycle(1'b1, 1'b0, 1'b0, IO + 5, 0, 16'h0, seen);
            check("presc_match", seen, 32'd1);
        end
`endif

        for (int n = 0; n < 2000; n++) begin
            r  = ($urandom_range(0, 99) == 0);
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                a  = {1'b0, 31'($urandom)};
                wd = $urandom;
            end else begin
                a = {1'b1, 27'($urandom), 4'($urandom_range(0, 7))};
                case (int'(a[3:0]))
                    2: wd = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3)
                                                         : $urandom_range(0, 30);
                    3: wd = $urandom_range(0, 30);
                    6: wd = $urandom_range(0, 3);
                    default: wd = $urandom;
                endcase
            end
            cycle(1'b1, r, we, a, wd, 16'($urandom), seen);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
